// File: rtl/bus_arbiter.sv
// Four-source arbiter for the shared 16-bit datapath bus. It produces registered,
// mutually exclusive drive enables, with round-robin or fixed priority and bounded ownership locks.
module bus_arbiter #(
   parameter int MAX_HOLD  = 4,
   parameter int PRIO_MODE = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] lock,
   output logic       alu_out_en,
   output logic       mem_out_en,
   output logic       reg_out_en,
   output logic       ctl_out_en,
   output logic [1:0] owner,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic {IDLE, OWNED} state_t;
   typedef enum logic [2:0] {ACT_NONE, ACT_KEEP, ACT_SWITCH, ACT_PREEMPT, ACT_RELEASE} action_t;

   localparam logic [3:0] MaxHold   = 4'(MAX_HOLD);
   localparam bit         FixedMode = (PRIO_MODE != 0);

   state_t     r_state;
   logic [3:0] r_grant;
   logic [1:0] r_owner;
   logic [3:0] r_holdCnt;
   logic       r_timeout;
   logic [1:0] r_rrPtr;

   state_t     w_nextState;
   action_t    w_action;
   logic [3:0] w_ownerMask;
   logic [3:0] w_others;
   logic [2:0] w_winAll;
   logic [2:0] w_winOthers;
   logic [1:0] w_winIdx;
   logic [3:0] w_nextGrant;
   logic [1:0] w_nextOwner;
   logic [3:0] w_nextHold;
   logic       w_nextTimeout;
   logic [1:0] w_nextRrPtr;

   // Returns {found, index}. The round-robin search starts at 'start'; fixed mode picks the lowest index.
   function automatic logic [2:0] pickWinner(input logic [3:0] mask, input logic [1:0] start);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = FixedMode ? 2'(i) : start + 2'(i);
         if (mask[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign w_ownerMask = 4'b0001 << r_owner;
   assign w_others    = req & ~w_ownerMask;
   assign w_winAll    = pickWinner(req, r_rrPtr);
   assign w_winOthers = pickWinner(w_others, r_rrPtr);
   assign w_winIdx    = (r_state == IDLE) ? w_winAll[1:0] : w_winOthers[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_grant   <= 4'b0000;
         r_owner   <= 2'd0;
         r_holdCnt <= 4'd0;
         r_timeout <= 1'b0;
         r_rrPtr   <= 2'd0;
      end else begin
         r_state   <= w_nextState;
         r_grant   <= w_nextGrant;
         r_owner   <= w_nextOwner;
         r_holdCnt <= w_nextHold;
         r_timeout <= w_nextTimeout;
         r_rrPtr   <= w_nextRrPtr;
      end
   end

   // A locked owner yields only once it has used its hold budget and someone else is waiting.
   always_comb begin
      w_nextState = r_state;
      w_action    = ACT_NONE;
      case (r_state)
         IDLE: begin
            if (w_winAll[2]) begin
               w_action    = ACT_SWITCH;
               w_nextState = OWNED;
            end
         end
         OWNED: begin
            if (req[r_owner]) begin
               if (lock[r_owner]) begin
                  if ((r_holdCnt < MaxHold) || !(|w_others)) w_action = ACT_KEEP;
                  else                                       w_action = ACT_PREEMPT;
               end else if (|w_others) begin
                  w_action = ACT_SWITCH;
               end else begin
                  w_action = ACT_KEEP;
               end
            end else if (|w_others) begin
               w_action = ACT_SWITCH;
            end else begin
               w_action    = ACT_RELEASE;
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      w_nextGrant   = r_grant;
      w_nextOwner   = r_owner;
      w_nextHold    = r_holdCnt;
      w_nextTimeout = 1'b0;
      w_nextRrPtr   = r_rrPtr;
      case (w_action)
         ACT_KEEP: begin
            if (r_holdCnt < MaxHold) w_nextHold = r_holdCnt + 4'd1;
         end
         ACT_SWITCH, ACT_PREEMPT: begin
            w_nextGrant   = 4'b0001 << w_winIdx;
            w_nextOwner   = w_winIdx;
            w_nextHold    = 4'd1;
            w_nextRrPtr   = w_winIdx + 2'd1;
            w_nextTimeout = (w_action == ACT_PREEMPT);
         end
         ACT_RELEASE: begin
            w_nextGrant = 4'b0000;
            w_nextHold  = 4'd0;
         end
         default: ;
      endcase
   end

   assign {ctl_out_en, reg_out_en, mem_out_en, alu_out_en} = r_grant;
   assign owner   = r_owner;
   assign busy    = |r_grant;
   assign timeout = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. It drives a round-robin instance and a fixed-priority instance
// from shared stimulus. Observed vectors are {timeout, busy, owner, ctl, reg, mem, alu}.
module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] lock;

   logic       aAlu, aMem, aReg, aCtl, aBusy, aTimeout;
   logic [1:0] aOwner;
   logic       bAlu, bMem, bReg, bCtl, bBusy, bTimeout;
   logic [1:0] bOwner;
   logic [7:0] obsA, obsB;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.MAX_HOLD(4), .PRIO_MODE(0)) uA (
      .clk(clk), .rst(rst), .req(req), .lock(lock),
      .alu_out_en(aAlu), .mem_out_en(aMem), .reg_out_en(aReg), .ctl_out_en(aCtl),
      .owner(aOwner), .busy(aBusy), .timeout(aTimeout)
   );

   bus_arbiter #(.MAX_HOLD(4), .PRIO_MODE(1)) uB (
      .clk(clk), .rst(rst), .req(req), .lock(lock),
      .alu_out_en(bAlu), .mem_out_en(bMem), .reg_out_en(bReg), .ctl_out_en(bCtl),
      .owner(bOwner), .busy(bBusy), .timeout(bTimeout)
   );

   assign obsA = {aTimeout, aBusy, aOwner, aCtl, aReg, aMem, aAlu};
   assign obsB = {bTimeout, bBusy, bOwner, bCtl, bReg, bMem, bAlu};

   // Drive the inputs just after an edge, then sample 1 time unit after the next edge.
   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
      req  = r;
      lock = l;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      req  = 4'b0000;
      lock = 4'b0000;
      rst  = 1'b1;
      #1 rst = 1'b0;
      #1;
      checkOutput("resetA", obsA, 8'b0000_0000);
      checkOutput("resetB", obsB, 8'b0000_0000);
      @(posedge clk);
      #1 rst = 1'b1;

      $display("[TB] round-robin rotation");
      applyStimulus(4'b1111, 4'b0000);
      checkOutput("rrAlu", obsA, 8'b0100_0001);
      applyStimulus(4'b1111, 4'b0000);
      checkOutput("rrMem", obsA, 8'b0101_0010);
      checkOutput("fixMem", obsB, 8'b0101_0010);
      applyStimulus(4'b1111, 4'b0000);
      checkOutput("rrReg", obsA, 8'b0110_0100);
      checkOutput("fixAlu", obsB, 8'b0100_0001);
      applyStimulus(4'b1111, 4'b0000);
      checkOutput("rrCtl", obsA, 8'b0111_1000);
      applyStimulus(4'b1111, 4'b0000);
      checkOutput("rrWrap", obsA, 8'b0100_0001);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("rrIdle", obsA, 8'b0000_0000);

      $display("[TB] lock timeout preemption");
      applyStimulus(4'b0010, 4'b0010);
      checkOutput("lockGrant", obsA, 8'b0101_0010);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0011, 4'b0010);
         checkOutput("lockHold", obsA, 8'b0101_0010);
      end
      applyStimulus(4'b0011, 4'b0010);
      checkOutput("preempt", obsA, 8'b1100_0001);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("timeoutPulse", obsA, 8'b0000_0000);

      $display("[TB] single locked source saturates");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(4'b0100, 4'b0100);
         checkOutput("soloReg", obsA, 8'b0110_0100);
      end
      checkOutput("holdSat", {4'b0000, uA.r_holdCnt}, 8'd4);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("soloRelease", obsA, 8'b0010_0000);

      $display("[TB] release to idle keeps owner");
      applyStimulus(4'b1000, 4'b0000);
      checkOutput("ctlGrant", obsA, 8'b0111_1000);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("ctlIdle", obsA, 8'b0011_0000);
      applyStimulus(4'b0001, 4'b0000);
      checkOutput("aluAfterIdle", obsA, 8'b0100_0001);

      $display("[TB] asynchronous reset mid-lock");
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("preLockIdle", obsA, 8'b0000_0000);
      applyStimulus(4'b0010, 4'b0010);
      checkOutput("midLockGrant", obsA, 8'b0101_0010);
      applyStimulus(4'b0010, 4'b0010);
      checkOutput("midLockHold", obsA, 8'b0101_0010);
      #2 rst = 1'b0;
      #1;
      checkOutput("asyncResetA", obsA, 8'b0000_0000);
      checkOutput("asyncResetB", obsB, 8'b0000_0000);
      req  = 4'b1111;
      lock = 4'b0000;
      rst  = 1'b1;
      applyStimulus(4'b1111, 4'b0000);
      checkOutput("postResetA", obsA, 8'b0100_0001);
      checkOutput("postResetB", obsB, 8'b0100_0001);

      $display("[TB] fixed priority handoff");
      applyStimulus(4'b1110, 4'b0000);
      checkOutput("fixMemWin", obsB, 8'b0101_0010);
      applyStimulus(4'b1100, 4'b0100);
      checkOutput("fixRegWin", obsB, 8'b0110_0100);
      applyStimulus(4'b1100, 4'b0100);
      checkOutput("fixRegHold", obsB, 8'b0110_0100);
      applyStimulus(4'b1000, 4'b0000);
      checkOutput("fixCtlAfter", obsB, 8'b0111_1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
